// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: times external SRAM write/read cycles and tracks read-compare errors
module sram_access_ctrl #(
  parameter int WR_CYCLES = 2,
  parameter int RD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        wr_req,
  input  logic        rd_req,
  input  logic [17:0] addr,
  input  logic [5:0]  pattern,
  input  logic        err_clr,
  output logic [17:0] sram_a,
  output logic        sram_ce_n,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] err_cnt,
  output logic [17:0] first_err_addr,
  output logic [15:0] first_err_data,
  output logic        overrun
);
  typedef enum logic [2:0] {IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT, RD_CMP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [15:0] rd_data;
  logic [15:0] word;
  logic drop;
  logic mism;
  assign word = {pattern, addr[9:0]};
  assign drop = busy ? (wr_req || rd_req) : (wr_req && rd_req);
  assign mism = (state == RD_CMP) && (rd_data != sram_dq_o);
  // Bus-cycle FSM with registered strobes, plus error statistics updated alongside
  always_ff @(posedge clk) begin
    if (!clr) begin
      state          <= IDLE;
      cnt            <= '0;
      rd_data        <= '0;
      sram_a         <= '0;
      sram_ce_n      <= 1'b1;
      sram_we_n      <= 1'b1;
      sram_oe_n      <= 1'b1;
      sram_dq_o      <= '0;
      sram_dq_oe     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      overrun        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            state      <= WR_SETUP;
            sram_a     <= addr;
            sram_dq_o  <= word;
            sram_ce_n  <= 1'b0;
            sram_dq_oe <= 1'b1;
            busy       <= 1'b1;
          end else if (rd_req) begin
            state     <= RD_WAIT;
            sram_a    <= addr;
            sram_dq_o <= word;
            sram_ce_n <= 1'b0;
            sram_oe_n <= 1'b0;
            busy      <= 1'b1;
            cnt       <= 4'(RD_CYCLES - 1);
          end
        end
        WR_SETUP: begin
          state     <= WR_PULSE;
          sram_we_n <= 1'b0;
          cnt       <= 4'(WR_CYCLES - 1);
        end
        WR_PULSE: begin
          if (cnt == 4'd0) begin
            state     <= WR_HOLD;
            sram_we_n <= 1'b1;
            done      <= 1'b1;
          end else cnt <= cnt - 4'd1;
        end
        WR_HOLD: begin
          state      <= IDLE;
          sram_ce_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
          busy       <= 1'b0;
        end
        RD_WAIT: begin
          if (cnt == 4'd0) begin
            state   <= RD_CMP;
            rd_data <= sram_dq_i;
            done    <= 1'b1;
          end else cnt <= cnt - 4'd1;
        end
        RD_CMP: begin
          state     <= IDLE;
          sram_ce_n <= 1'b1;
          sram_oe_n <= 1'b1;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (err_clr) begin
        err            <= 1'b0;
        err_cnt        <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
        overrun        <= 1'b0;
      end else begin
        if (drop) overrun <= 1'b1;
        if (mism) begin
          err_cnt <= (err_cnt == 16'hFFFF) ? err_cnt : err_cnt + 16'd1;
          if (!err) begin
            first_err_addr <= sram_a;
            first_err_data <= rd_data;
          end
          err <= 1'b1;
        end
      end
    end
  end
endmodule
